// File: rtl/axi_defines.sv
// rtl/axi_defines.sv - AXI4-Lite channel types, response codes and FSM states
package axi_defines;

    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 32;
    localparam int AXI_STRB_W = AXI_DATA_W / 8;

    typedef struct packed {
        logic                  valid;
        logic [AXI_ADDR_W-1:0] addr;
    } aw_t;

    typedef struct packed {
        logic                  valid;
        logic [AXI_ADDR_W-1:0] addr;
    } ar_t;

    typedef struct packed {
        logic                  valid;
        logic [AXI_DATA_W-1:0] data;
        logic [AXI_STRB_W-1:0] strb;
    } w_t;

    typedef struct packed {
        logic       valid;
        logic [1:0] resp;
    } b_t;

    typedef struct packed {
        logic                  valid;
        logic [AXI_DATA_W-1:0] data;
        logic [1:0]            resp;
    } r_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        WR_IDLE,
        WR_RESP
    } wr_state_e;

    typedef enum logic {
        RD_IDLE,
        RD_RESP
    } rd_state_e;

endpackage

// File: rtl/axi_inf.sv
// rtl/axi_inf.sv - AXI4-Lite bus bundle with master and slave views
interface axi_inf;
    import axi_defines::*;

    aw_t  aw;
    w_t   w;
    ar_t  ar;
    b_t   b;
    r_t   r;
    logic awready;
    logic wready;
    logic arready;
    logic bready;
    logic rready;

    modport master (
        output aw, w, ar, bready, rready,
        input  b, r, awready, wready, arready
    );

    modport slave (
        input  aw, w, ar, bready, rready,
        output b, r, awready, wready, arready
    );

endinterface

// File: rtl/axi_lite_ram_array.sv
// rtl/axi_lite_ram_array.sv - byte-writable word RAM, registered read-first port
module axi_lite_ram_array #(
    parameter int DEPTH  = 1024,
    parameter int DATA_W = 32,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  we_i,
    input  logic [IDX_W-1:0]      waddr_i,
    input  logic [DATA_W-1:0]     wdata_i,
    input  logic [DATA_W/8-1:0]   wstrb_i,
    input  logic                  re_i,
    input  logic [IDX_W-1:0]      raddr_i,
    output logic [DATA_W-1:0]     rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Byte-lane write; contents survive reset
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int i = 0; i < DATA_W / 8; i++) begin
                if (wstrb_i[i]) begin
                    mem_q[waddr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
                end
            end
        end
    end

    // Registered read that holds between enables; sees the pre-write word on a collision
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/axi_lite_slave_mem.sv
// rtl/axi_lite_slave_mem.sv - AXI4-Lite responder backed by on-chip RAM
module axi_lite_slave_mem
    import axi_defines::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                DEPTH     = 1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic   clk,
    input  logic   rst_n,
    axi_inf.slave  bus
);

    localparam int                IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] SPAN  = ADDR_W'(DEPTH * 4);

    wr_state_e           wr_q, wr_d;
    logic                aw_cap_q, aw_cap_d, w_cap_q, w_cap_d;
    logic                awready_q, awready_d, wready_q, wready_d;
    logic                bvalid_q, bvalid_d;
    logic [1:0]          bresp_q, bresp_d;
    logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W/8-1:0] wstrb_q, wstrb_d;

    rd_state_e           rd_q, rd_d;
    logic                arready_q, arready_d;
    logic                rvalid_q, rvalid_d;
    logic [1:0]          rresp_q, rresp_d;

    logic                aw_hs, w_hs, ar_hs;
    logic [ADDR_W-1:0]   wr_addr, wr_off, rd_off;
    logic [DATA_W-1:0]   wr_data;
    logic [DATA_W/8-1:0] wr_strb;
    logic                wr_in_range, rd_in_range;
    logic                ram_we, ram_re;
    logic [DATA_W-1:0]   ram_rdata;

    // Address decode; the subtraction wraps below BASE_ADDR so a single compare covers both bounds
    always_comb begin
        aw_hs       = bus.aw.valid & awready_q;
        w_hs        = bus.w.valid & wready_q;
        ar_hs       = bus.ar.valid & arready_q;
        wr_addr     = aw_cap_q ? awaddr_q : bus.aw.addr;
        wr_data     = w_cap_q ? wdata_q : bus.w.data;
        wr_strb     = w_cap_q ? wstrb_q : bus.w.strb;
        wr_off      = wr_addr - BASE_ADDR;
        rd_off      = bus.ar.addr - BASE_ADDR;
        wr_in_range = wr_off < SPAN;
        rd_in_range = rd_off < SPAN;
    end

    // Write FSM: collect AW and W in any order, commit once both are held, then wait for B
    always_comb begin
        wr_d      = wr_q;
        aw_cap_d  = aw_cap_q;
        w_cap_d   = w_cap_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        ram_we    = 1'b0;
        case (wr_q)
            WR_IDLE: begin
                if (aw_hs) begin
                    aw_cap_d = 1'b1;
                    awaddr_d = bus.aw.addr;
                end
                if (w_hs) begin
                    w_cap_d = 1'b1;
                    wdata_d = bus.w.data;
                    wstrb_d = bus.w.strb;
                end
                if ((aw_cap_q | aw_hs) && (w_cap_q | w_hs)) begin
                    ram_we    = wr_in_range;
                    bvalid_d  = 1'b1;
                    bresp_d   = wr_in_range ? RESP_OKAY : RESP_SLVERR;
                    awready_d = 1'b0;
                    wready_d  = 1'b0;
                    wr_d      = WR_RESP;
                end else begin
                    awready_d = !(aw_cap_q | aw_hs);
                    wready_d  = !(w_cap_q | w_hs);
                end
            end
            WR_RESP: begin
                if (bus.bready) begin
                    bvalid_d  = 1'b0;
                    aw_cap_d  = 1'b0;
                    w_cap_d   = 1'b0;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                    wr_d      = WR_IDLE;
                end
            end
            default: wr_d = WR_IDLE;
        endcase
    end

    // Read FSM: one-cycle RAM lookup on AR, hold R until accepted
    always_comb begin
        rd_d      = rd_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rresp_d   = rresp_q;
        ram_re    = 1'b0;
        case (rd_q)
            RD_IDLE: begin
                if (ar_hs) begin
                    ram_re    = rd_in_range;
                    rresp_d   = rd_in_range ? RESP_OKAY : RESP_SLVERR;
                    rvalid_d  = 1'b1;
                    arready_d = 1'b0;
                    rd_d      = RD_RESP;
                end else begin
                    arready_d = 1'b1;
                end
            end
            RD_RESP: begin
                if (bus.rready) begin
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                    rd_d      = RD_IDLE;
                end
            end
            default: rd_d = RD_IDLE;
        endcase
    end

    // State and channel registers; reset abandons any transaction in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q      <= WR_IDLE;
            aw_cap_q  <= 1'b0;
            w_cap_q   <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rd_q      <= RD_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
        end else begin
            wr_q      <= wr_d;
            aw_cap_q  <= aw_cap_d;
            w_cap_q   <= w_cap_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rd_q      <= rd_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
        end
    end

    axi_lite_ram_array #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_ram (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .we_i    (ram_we),
        .waddr_i (wr_off[IDX_W+1:2]),
        .wdata_i (wr_data),
        .wstrb_i (wr_strb),
        .re_i    (ram_re),
        .raddr_i (rd_off[IDX_W+1:2]),
        .rdata_o (ram_rdata)
    );

    // An SLVERR read reports zero data regardless of what the RAM register holds
    assign bus.awready = awready_q;
    assign bus.wready  = wready_q;
    assign bus.arready = arready_q;
    assign bus.b       = '{valid: bvalid_q, resp: bresp_q};
    assign bus.r       = '{valid: rvalid_q,
                           data:  (rresp_q == RESP_SLVERR) ? '0 : ram_rdata,
                           resp:  rresp_q};

endmodule

// File: tb/tb_axi_lite_slave_mem.sv
// tb/tb_axi_lite_slave_mem.sv - directed-vector bench for axi_lite_slave_mem
module tb_axi_lite_slave_mem;
    import axi_defines::*;

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;

    axi_inf bus ();

    axi_lite_slave_mem #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .DEPTH     (1024),
        .BASE_ADDR (32'h0000_0000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Called just after a falling edge; same-cycle AW+W, bready high
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp, output int lat);
        bus.aw.valid = 1'b1; bus.aw.addr = a;
        bus.w.valid  = 1'b1; bus.w.data  = d; bus.w.strb = s;
        bus.bready   = 1'b1;
        lat  = 0;
        resp = 2'b11;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (bus.b.valid) begin
                resp = bus.b.resp;
                break;
            end
        end
        bus.aw.valid = 1'b0;
        bus.w.valid  = 1'b0;
        expect_eq("wr_bvalid_seen", {31'd0, bus.b.valid}, 32'd1);
        @(negedge clk);
        bus.bready = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] d,
                           output logic [1:0] resp, output int lat);
        bus.ar.valid = 1'b1; bus.ar.addr = a;
        bus.rready   = 1'b0;
        lat  = 0;
        d    = 32'hxxxx_xxxx;
        resp = 2'b11;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (bus.r.valid) begin
                d    = bus.r.data;
                resp = bus.r.resp;
                break;
            end
        end
        bus.ar.valid = 1'b0;
        expect_eq("rd_rvalid_seen", {31'd0, bus.r.valid}, 32'd1);
        bus.rready = 1'b1;
        @(negedge clk);
        bus.rready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  resp;
        logic [31:0] data;
        int          lat;

        bus.aw = '0; bus.w = '0; bus.ar = '0;
        bus.bready = 1'b0; bus.rready = 1'b0;

        // Reset with valids asserted
        rst_n = 1'b0;
        bus.aw.valid = 1'b1;
        bus.ar.valid = 1'b1;
        repeat (3) @(negedge clk);
        expect_eq("rst_awready", {31'd0, bus.awready}, 32'd0);
        expect_eq("rst_wready",  {31'd0, bus.wready},  32'd0);
        expect_eq("rst_arready", {31'd0, bus.arready}, 32'd0);
        expect_eq("rst_bvalid",  {31'd0, bus.b.valid}, 32'd0);
        expect_eq("rst_rvalid",  {31'd0, bus.r.valid}, 32'd0);
        expect_eq("rst_rdata",   bus.r.data, 32'd0);
        bus.aw.valid = 1'b0;
        bus.ar.valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        expect_eq("rel_awready", {31'd0, bus.awready}, 32'd1);
        expect_eq("rel_wready",  {31'd0, bus.wready},  32'd1);
        expect_eq("rel_arready", {31'd0, bus.arready}, 32'd1);

        // Same-cycle write then read
        do_write(32'h10, 32'hDEAD_BEEF, 4'hF, resp, lat);
        expect_eq("wr1_resp", {30'd0, resp}, {30'd0, RESP_OKAY});
        expect_eq("wr1_lat",  lat, 32'd1);
        do_read(32'h10, data, resp, lat);
        expect_eq("rd1_data", data, 32'hDEAD_BEEF);
        expect_eq("rd1_resp", {30'd0, resp}, {30'd0, RESP_OKAY});
        expect_eq("rd1_lat",  lat, 32'd1);

        // W three cycles ahead of AW, partial strobe
        bus.w.valid = 1'b1; bus.w.data = 32'h1122_3344; bus.w.strb = 4'b0101;
        bus.bready  = 1'b1;
        @(negedge clk);
        bus.w.valid = 1'b0;
        expect_eq("wfirst_wready",  {31'd0, bus.wready},  32'd0);
        expect_eq("wfirst_awready", {31'd0, bus.awready}, 32'd1);
        expect_eq("wfirst_bvalid0", {31'd0, bus.b.valid}, 32'd0);
        repeat (2) begin
            @(negedge clk);
            expect_eq("wfirst_bvalid_wait", {31'd0, bus.b.valid}, 32'd0);
        end
        bus.aw.valid = 1'b1; bus.aw.addr = 32'h10;
        @(negedge clk);
        bus.aw.valid = 1'b0;
        expect_eq("wfirst_bvalid1", {31'd0, bus.b.valid}, 32'd1);
        expect_eq("wfirst_bresp",   {30'd0, bus.b.resp}, {30'd0, RESP_OKAY});
        @(negedge clk);
        bus.bready = 1'b0;
        do_read(32'h10, data, resp, lat);
        expect_eq("strb_merge", data, 32'hDE22_BE44);

        // Backpressure on both response channels
        bus.aw.valid = 1'b1; bus.aw.addr = 32'h30;
        bus.w.valid  = 1'b1; bus.w.data  = 32'hCAFE_F00D; bus.w.strb = 4'hF;
        bus.ar.valid = 1'b1; bus.ar.addr = 32'h10;
        bus.bready = 1'b0; bus.rready = 1'b0;
        @(negedge clk);
        bus.aw.valid = 1'b0; bus.w.valid = 1'b0; bus.ar.valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            expect_eq("bp_rvalid",  {31'd0, bus.r.valid}, 32'd1);
            expect_eq("bp_rdata",   bus.r.data, 32'hDE22_BE44);
            expect_eq("bp_bvalid",  {31'd0, bus.b.valid}, 32'd1);
            expect_eq("bp_bresp",   {30'd0, bus.b.resp}, {30'd0, RESP_OKAY});
            expect_eq("bp_readies", {29'd0, bus.arready, bus.awready, bus.wready}, 32'd0);
            @(negedge clk);
        end
        bus.bready = 1'b1; bus.rready = 1'b1;
        @(negedge clk);
        bus.bready = 1'b0; bus.rready = 1'b0;
        expect_eq("bp_rel_valids",  {30'd0, bus.r.valid, bus.b.valid}, 32'd0);
        expect_eq("bp_rel_readies", {29'd0, bus.arready, bus.awready, bus.wready}, 32'd7);
        do_read(32'h30, data, resp, lat);
        expect_eq("bp_wr_data", data, 32'hCAFE_F00D);

        // Out of range: one past the last word aliases word 0 if undecoded
        do_write(32'h0, 32'h0BAD_F00D, 4'hF, resp, lat);
        do_write(32'h1000, 32'hFFFF_FFFF, 4'hF, resp, lat);
        expect_eq("oor_bresp", {30'd0, resp}, {30'd0, RESP_SLVERR});
        do_read(32'h1000, data, resp, lat);
        expect_eq("oor_rresp", {30'd0, resp}, {30'd0, RESP_SLVERR});
        expect_eq("oor_rdata", data, 32'd0);
        do_read(32'h0, data, resp, lat);
        expect_eq("oor_word0", data, 32'h0BAD_F00D);
        expect_eq("oor_word0_resp", {30'd0, resp}, {30'd0, RESP_OKAY});

        // Zero strobe leaves memory untouched
        do_write(32'h0, 32'h1234_5678, 4'h0, resp, lat);
        expect_eq("strb0_resp", {30'd0, resp}, {30'd0, RESP_OKAY});
        do_read(32'h0, data, resp, lat);
        expect_eq("strb0_data", data, 32'h0BAD_F00D);

        // Read/write collision on one word: read returns the old value
        do_write(32'h20, 32'h5, 4'hF, resp, lat);
        bus.aw.valid = 1'b1; bus.aw.addr = 32'h20;
        bus.bready = 1'b1;
        @(negedge clk);
        bus.aw.valid = 1'b0;
        bus.w.valid  = 1'b1; bus.w.data = 32'h9; bus.w.strb = 4'hF;
        bus.ar.valid = 1'b1; bus.ar.addr = 32'h20;
        @(negedge clk);
        bus.w.valid = 1'b0; bus.ar.valid = 1'b0;
        expect_eq("coll_rvalid", {31'd0, bus.r.valid}, 32'd1);
        expect_eq("coll_rdata",  bus.r.data, 32'h5);
        expect_eq("coll_bvalid", {31'd0, bus.b.valid}, 32'd1);
        bus.rready = 1'b1;
        @(negedge clk);
        bus.rready = 1'b0; bus.bready = 1'b0;
        do_read(32'h20, data, resp, lat);
        expect_eq("coll_after", data, 32'h9);

        // Reset while a B response is pending
        bus.aw.valid = 1'b1; bus.aw.addr = 32'h40;
        bus.w.valid  = 1'b1; bus.w.data  = 32'h77; bus.w.strb = 4'hF;
        bus.bready = 1'b0;
        @(negedge clk);
        bus.aw.valid = 1'b0; bus.w.valid = 1'b0;
        expect_eq("abort_bvalid_pre", {31'd0, bus.b.valid}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        expect_eq("abort_bvalid_rst", {31'd0, bus.b.valid}, 32'd0);
        rst_n = 1'b1;
        bus.bready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            expect_eq("abort_no_b", {31'd0, bus.b.valid}, 32'd0);
        end
        bus.bready = 1'b0;
        expect_eq("abort_readies", {29'd0, bus.arready, bus.awready, bus.wready}, 32'd7);
        do_read(32'h20, data, resp, lat);
        expect_eq("mem_kept_over_rst", data, 32'h9);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
